// File: rtl/fpu_pkg.sv
// Shared FP pipeline constants: register file size, issue latency classes
// and the scoreboard latency-field width derived from them.
package fpu_pkg;

    localparam int unsigned FP_NUM_REGS = 32;
    localparam int unsigned FP_MAX_LAT  = 4;
    localparam int unsigned FP_RA_W     = $clog2(FP_NUM_REGS);
    localparam int unsigned FP_LAT_W    = $clog2(FP_MAX_LAT + 1);

    typedef logic [FP_LAT_W-1:0] fp_lat_t;

    // Result latency per decode class; LAT_NONE means the result is not tracked
    localparam fp_lat_t LAT_NONE = FP_LAT_W'(0);
    localparam fp_lat_t LAT_ADSB = FP_LAT_W'(1);
    localparam fp_lat_t LAT_CVIF = FP_LAT_W'(1);
    localparam fp_lat_t LAT_MULT = FP_LAT_W'(2);
    localparam fp_lat_t LAT_LOAD = FP_LAT_W'(2);
    localparam fp_lat_t LAT_FMAD = FP_LAT_W'(4);

endpackage

// File: rtl/fpu_sb_counter.sv
// Per-register in-flight countdown: loads the op latency on issue, otherwise
// decrements toward zero; a load wins over the decrement in the same cycle.
module fpu_sb_counter
    import fpu_pkg::*;
#(
    parameter int unsigned LAT_W = FP_LAT_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    output logic [LAT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - LAT_W'(1);
        end
    end

endmodule

// File: rtl/fpu_scoreboard.sv
// FP issue scoreboard: per-register result countdowns plus a writeback-slot
// reservation vector; stalls issue on RAW, WAW and writeback-port conflicts.
module fpu_scoreboard
    import fpu_pkg::*;
#(
    parameter int unsigned NUM_REGS = FP_NUM_REGS,
    parameter int unsigned MAX_LAT  = FP_MAX_LAT,
    parameter bit          FWD_EN   = 1'b1,
    parameter int unsigned RA_W     = $clog2(NUM_REGS),
    parameter int unsigned LAT_W    = $clog2(MAX_LAT + 1)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                dec_valid,
    input  logic                dec_reg_write,
    input  logic [RA_W-1:0]     dec_rd,
    input  logic [LAT_W-1:0]    dec_lat,
    input  logic                dec_use_rs1,
    input  logic                dec_use_rs2,
    input  logic                dec_use_rs3,
    input  logic [RA_W-1:0]     dec_rs1,
    input  logic [RA_W-1:0]     dec_rs2,
    input  logic [RA_W-1:0]     dec_rs3,
    input  logic                flush,
    output logic                issue_stall,
    output logic                issue_fire,
    output logic [NUM_REGS-1:0] reg_busy,
    output logic                wb_due,
    output logic                any_busy,
    output logic [31:0]         stall_cycles
);

    logic [LAT_W-1:0] cnt [NUM_REGS];
    logic [MAX_LAT:1] pend;
    logic [MAX_LAT:1] pend_nxt;
    logic [LAT_W-1:0] cnt_rs1, cnt_rs2, cnt_rs3, cnt_rd;
    logic             tracked, track, raw, waw, port_hit;

    // A source is blocked while its producer is still more than a bypass away
    function automatic logic src_hazard(input logic use_src, input logic [LAT_W-1:0] c);
        if (FWD_EN) begin
            return use_src && (c > LAT_W'(1));
        end
        return use_src && (c != '0);
    endfunction

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
        fpu_sb_counter #(.LAT_W(LAT_W)) u_cnt (
            .clk      (clk),
            .rstn     (rstn),
            .load     (track && (dec_rd == RA_W'(r))),
            .load_val (dec_lat),
            .cnt      (cnt[r])
        );
        assign reg_busy[r] = (cnt[r] != '0);
    end

    assign cnt_rs1 = cnt[dec_rs1];
    assign cnt_rs2 = cnt[dec_rs2];
    assign cnt_rs3 = cnt[dec_rs3];
    assign cnt_rd  = cnt[dec_rd];

    assign tracked = dec_reg_write && (dec_lat != '0);
    assign raw     = src_hazard(dec_use_rs1, cnt_rs1) ||
                     src_hazard(dec_use_rs2, cnt_rs2) ||
                     src_hazard(dec_use_rs3, cnt_rs3);
    // A younger write may not land before an older one to the same register
    assign waw     = dec_reg_write && (cnt_rd > dec_lat);

    // Writeback slot dec_lat is taken if some op currently sits at dec_lat+1
    always_comb begin
        port_hit = 1'b0;
        for (int unsigned k = 2; k <= MAX_LAT; k++) begin
            if (pend[k] && (32'(dec_lat) + 32'd1 == k)) begin
                port_hit = 1'b1;
            end
        end
    end

    assign issue_stall = dec_valid && (raw || waw || (tracked && port_hit));
    assign issue_fire  = dec_valid && !issue_stall && !flush;
    assign track       = issue_fire && tracked;
    assign wb_due      = pend[1];
    assign any_busy    = |reg_busy;

    always_comb begin
        pend_nxt = pend >> 1;
        for (int unsigned k = 1; k <= MAX_LAT; k++) begin
            if (track && (32'(dec_lat) == k)) begin
                pend_nxt[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend         <= '0;
            stall_cycles <= '0;
        end else begin
            pend <= pend_nxt;
            if (dec_valid && issue_stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end

    lat_legal: assert property (@(posedge clk) disable iff (!rstn)
        dec_valid |-> (32'(dec_lat) <= MAX_LAT));

endmodule

// File: tb/tb_fpu_scoreboard.sv
// Self-checking bench for fpu_scoreboard: hazard probe table, hand-written
// multi-cycle sequences, and a writeback-cycle scoreboard queue.
`timescale 1ns/100ps
module tb_fpu_scoreboard;

    logic        clk, rstn;
    logic        dec_valid, dec_valid0, dec_reg_write;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2, dec_rs3;
    logic [2:0]  dec_lat;
    logic        dec_use_rs1, dec_use_rs2, dec_use_rs3, flush;
    logic        issue_stall, issue_fire, wb_due, any_busy;
    logic [31:0] reg_busy, stall_cycles;
    logic        issue_stall0, issue_fire0, wb_due0, any_busy0;
    logic [31:0] reg_busy0, stall_cycles0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wb_q[$];

    typedef struct {
        logic       valid;
        logic       wr;
        logic [4:0] rd;
        logic [2:0] lat;
        logic       u1, u2, u3;
        logic [4:0] r1, r2, r3;
        logic       fl;
    } op_t;

    typedef struct {
        string name;
        op_t   o;
        bit    stall;
        bit    fire;
    } vec_t;

    fpu_scoreboard #(.FWD_EN(1'b1)) u_dut (
        .clk(clk), .rstn(rstn), .dec_valid(dec_valid), .dec_reg_write(dec_reg_write),
        .dec_rd(dec_rd), .dec_lat(dec_lat),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_use_rs3(dec_use_rs3),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs3(dec_rs3), .flush(flush),
        .issue_stall(issue_stall), .issue_fire(issue_fire), .reg_busy(reg_busy),
        .wb_due(wb_due), .any_busy(any_busy), .stall_cycles(stall_cycles)
    );

    fpu_scoreboard #(.FWD_EN(1'b0)) u_nofwd (
        .clk(clk), .rstn(rstn), .dec_valid(dec_valid0), .dec_reg_write(dec_reg_write),
        .dec_rd(dec_rd), .dec_lat(dec_lat),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_use_rs3(dec_use_rs3),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rs3(dec_rs3), .flush(flush),
        .issue_stall(issue_stall0), .issue_fire(issue_fire0), .reg_busy(reg_busy0),
        .wb_due(wb_due0), .any_busy(any_busy0), .stall_cycles(stall_cycles0)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Source argument < 0 means the source is unused
    function automatic op_t mk(input bit v, input bit w, input int rd, input int lat,
                               input int s1, input int s2, input int s3, input bit fl);
        op_t o;
        o.valid = v;  o.wr = w;  o.rd = 5'(rd);  o.lat = 3'(lat);
        o.u1 = (s1 >= 0);  o.r1 = 5'((s1 < 0) ? 0 : s1);
        o.u2 = (s2 >= 0);  o.r2 = 5'((s2 < 0) ? 0 : s2);
        o.u3 = (s3 >= 0);  o.r3 = 5'((s3 < 0) ? 0 : s3);
        o.fl = fl;
        return o;
    endfunction

    task automatic apply(input op_t o);
        dec_valid = o.valid;  dec_reg_write = o.wr;  dec_rd = o.rd;  dec_lat = o.lat;
        dec_use_rs1 = o.u1;  dec_rs1 = o.r1;
        dec_use_rs2 = o.u2;  dec_rs2 = o.r2;
        dec_use_rs3 = o.u3;  dec_rs3 = o.r3;
        flush = o.fl;
    endtask

    task automatic expect_wb(input int c);
        int i = 0;
        while (i < wb_q.size() && wb_q[i] <= c) i++;
        wb_q.insert(i, c);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Scoreboard: every wb_due pulse must match the oldest expected writeback cycle
    always @(negedge clk) begin
        if (rstn) begin
            if (wb_q.size() != 0 && wb_q[0] < cyc) begin
                checks++;
                failures++;
                $display("FAIL wb_missed: expected writeback at cycle %0d, none by %0d", wb_q[0], cyc);
                void'(wb_q.pop_front());
            end
            if (wb_due) begin
                if (wb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wb_unexpected: wb_due=1 at cycle %0d, none expected", cyc);
                end else begin
                    check("wb_cycle", 32'(cyc), 32'(wb_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[15];
        op_t  idle;
        idle = mk(0, 0, 0, 0, -1, -1, -1, 0);

        rstn = 1'b1;
        dec_valid0 = 1'b0;
        apply(idle);
        #1 rstn = 1'b0;
        #5;
        check("rst_reg_busy", reg_busy, 32'h0);
        check("rst_wb_due", 32'(wb_due), 32'h0);
        check("rst_any_busy", 32'(any_busy), 32'h0);
        check("rst_stall_cycles", stall_cycles, 32'h0);
        check("rst_issue_stall", 32'(issue_stall), 32'h0);
        check("rst_issue_fire", 32'(issue_fire), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        next_cycle();

        // Dependency chain: fmad f3 (lat 4) then fadd f4 <- f3, both forwarding modes
        apply(mk(1, 1, 3, 4, -1, -1, -1, 0));
        dec_valid0 = 1'b1;
        mid();
        check("chain_fmad_fire", 32'(issue_fire), 32'h1);
        check("chain_fmad_fire_nofwd", 32'(issue_fire0), 32'h1);
        expect_wb(cyc + 4);
        next_cycle();
        apply(mk(1, 1, 4, 1, 3, -1, -1, 0));
        for (int k = 1; k <= 5; k++) begin
            dec_valid  = (k <= 4);
            dec_valid0 = (k <= 5);
            mid();
            check("chain_stall_fwd", 32'(issue_stall), 32'(k <= 3));
            check("chain_fire_fwd", 32'(issue_fire), 32'(k == 4));
            check("chain_stall_nofwd", 32'(issue_stall0), 32'(k <= 4));
            check("chain_fire_nofwd", 32'(issue_fire0), 32'(k == 5));
            if (k == 4) expect_wb(cyc + 1);
            next_cycle();
        end
        dec_valid0 = 1'b0;
        apply(idle);
        mid();
        check("chain_stall_cycles_fwd", stall_cycles, 32'd3);
        check("chain_stall_cycles_nofwd", stall_cycles0, 32'd4);
        next_cycle();
        repeat (2) next_cycle();
        mid();
        check("chain_drained", 32'(any_busy), 32'h0);
        next_cycle();

        // Hazard probe table against cnt[3]=3, cnt[5]=2, slots 3 and 2 reserved
        vecs[0]  = '{"raw_rs1_f3",      mk(1, 0, 0, 0,  3, -1, -1, 1), 1, 0};
        vecs[1]  = '{"raw_rs2_f5",      mk(1, 0, 0, 0, -1,  5, -1, 1), 1, 0};
        vecs[2]  = '{"raw_rs3_f3",      mk(1, 0, 0, 0, -1, -1,  3, 1), 1, 0};
        vecs[3]  = '{"free_sources",    mk(1, 0, 0, 0,  1,  2,  4, 0), 0, 1};
        vecs[4]  = '{"port_lat1",       mk(1, 1, 1, 1, -1, -1, -1, 0), 1, 0};
        vecs[5]  = '{"port_lat2",       mk(1, 1, 1, 2, -1, -1, -1, 0), 1, 0};
        vecs[6]  = '{"lat3_free_slot",  mk(1, 1, 1, 3, -1, -1, -1, 0), 0, 1};
        vecs[7]  = '{"lat_max_noport",  mk(1, 1, 1, 4, -1, -1, -1, 0), 0, 1};
        vecs[8]  = '{"waw_untracked",   mk(1, 1, 3, 0, -1, -1, -1, 0), 1, 0};
        vecs[9]  = '{"waw_longer_ok",   mk(1, 1, 5, 4, -1, -1, -1, 0), 0, 1};
        vecs[10] = '{"untracked_noport", mk(1, 0, 1, 1, -1, -1, -1, 0), 0, 1};
        vecs[11] = '{"not_valid",       mk(0, 1, 3, 0,  3, -1, -1, 0), 0, 0};
        vecs[12] = '{"flush_clean",     mk(1, 1, 1, 3, -1, -1, -1, 1), 0, 0};
        vecs[13] = '{"self_source",     mk(1, 1, 1, 3,  1, -1, -1, 0), 0, 1};
        vecs[14] = '{"waw_equal_ok",    mk(1, 1, 3, 3, -1, -1, -1, 0), 0, 1};
        apply(mk(1, 1, 3, 4, -1, -1, -1, 0));
        mid();
        check("tbl_setup_fmad", 32'(issue_fire), 32'h1);
        expect_wb(cyc + 4);
        next_cycle();
        apply(mk(1, 1, 5, 2, -1, -1, -1, 0));
        mid();
        check("tbl_setup_mult", 32'(issue_fire), 32'h1);
        expect_wb(cyc + 2);
        next_cycle();
        for (int i = 0; i < 15; i++) begin
            apply(vecs[i].o);
            #1;
            check({vecs[i].name, "_stall"}, 32'(issue_stall), 32'(vecs[i].stall));
            check({vecs[i].name, "_fire"}, 32'(issue_fire), 32'(vecs[i].fire));
        end
        apply(idle);
        mid();
        check("tbl_reg_busy", reg_busy, 32'h0000_0028);
        check("tbl_wb_due", 32'(wb_due), 32'h0);
        next_cycle();
        repeat (4) next_cycle();

        // Port collision: mult f5 (lat 2), then fadd f6 (lat 1) one cycle later
        apply(mk(1, 1, 5, 2, -1, -1, -1, 0));
        mid();
        check("port_mult_fire", 32'(issue_fire), 32'h1);
        expect_wb(cyc + 2);
        next_cycle();
        apply(mk(1, 1, 6, 1, -1, -1, -1, 0));
        mid();
        check("port_fadd_stall", 32'(issue_stall), 32'h1);
        check("port_wb_c1", 32'(wb_due), 32'h0);
        next_cycle();
        mid();
        check("port_fadd_fire", 32'(issue_fire), 32'h1);
        check("port_wb_c2", 32'(wb_due), 32'h1);
        expect_wb(cyc + 1);
        next_cycle();
        apply(idle);
        mid();
        check("port_wb_c3", 32'(wb_due), 32'h1);
        next_cycle();
        mid();
        check("port_wb_c4", 32'(wb_due), 32'h0);
        check("port_stall_cycles", stall_cycles, 32'd4);
        next_cycle();

        // WAW: fmad f7 (lat 4), then fadd f7 (lat 1)
        apply(mk(1, 1, 7, 4, -1, -1, -1, 0));
        mid();
        check("waw_fmad_fire", 32'(issue_fire), 32'h1);
        check("waw_busy7_k0", 32'(reg_busy[7]), 32'h0);
        expect_wb(cyc + 4);
        next_cycle();
        apply(mk(1, 1, 7, 1, -1, -1, -1, 0));
        for (int k = 1; k <= 6; k++) begin
            dec_valid = (k <= 4);
            mid();
            check("waw_stall", 32'(issue_stall), 32'(k <= 3));
            check("waw_fire", 32'(issue_fire), 32'(k == 4));
            check("waw_busy7", 32'(reg_busy[7]), 32'(k <= 5));
            if (k == 4) expect_wb(cyc + 1);
            next_cycle();
        end
        apply(idle);

        // Flush: in-flight f9 keeps draining while a clean fmul f2 is flushed
        apply(mk(1, 1, 9, 4, -1, -1, -1, 0));
        mid();
        check("flush_f9_fire", 32'(issue_fire), 32'h1);
        expect_wb(cyc + 4);
        next_cycle();
        apply(mk(1, 1, 2, 2, -1, -1, -1, 1));
        mid();
        check("flush_stall", 32'(issue_stall), 32'h0);
        check("flush_fire", 32'(issue_fire), 32'h0);
        check("flush_busy9_k1", 32'(reg_busy[9]), 32'h1);
        next_cycle();
        apply(idle);
        for (int k = 2; k <= 5; k++) begin
            mid();
            check("flush_busy2", 32'(reg_busy[2]), 32'h0);
            check("flush_busy9", 32'(reg_busy[9]), 32'(k <= 4));
            next_cycle();
        end

        // Async reset with three ops in flight
        apply(mk(1, 1, 10, 4, -1, -1, -1, 0));
        mid();
        check("rst_f10_fire", 32'(issue_fire), 32'h1);
        expect_wb(cyc + 4);
        next_cycle();
        apply(mk(1, 1, 11, 2, -1, -1, -1, 0));
        mid();
        check("rst_f11_fire", 32'(issue_fire), 32'h1);
        expect_wb(cyc + 2);
        next_cycle();
        apply(mk(1, 1, 12, 4, -1, -1, -1, 0));
        mid();
        check("rst_f12_fire", 32'(issue_fire), 32'h1);
        expect_wb(cyc + 4);
        next_cycle();
        apply(idle);
        mid();
        check("rst_pre_any_busy", 32'(any_busy), 32'h1);
        check("rst_pre_wb_due", 32'(wb_due), 32'h1);
        #2;
        wb_q.delete();
        rstn = 1'b0;
        #1;
        check("rst_mid_reg_busy", reg_busy, 32'h0);
        check("rst_mid_wb_due", 32'(wb_due), 32'h0);
        check("rst_mid_any_busy", 32'(any_busy), 32'h0);
        check("rst_mid_stall_cycles", stall_cycles, 32'h0);
        rstn = 1'b1;
        next_cycle();
        apply(mk(1, 1, 13, 1, 10, -1, -1, 0));
        mid();
        check("rst_after_stall", 32'(issue_stall), 32'h0);
        check("rst_after_fire", 32'(issue_fire), 32'h1);
        expect_wb(cyc + 1);
        next_cycle();
        apply(idle);
        repeat (2) next_cycle();

        // Saturation of the stall counter
        apply(mk(1, 1, 14, 4, -1, -1, -1, 0));
        mid();
        check("sat_f14_fire", 32'(issue_fire), 32'h1);
        expect_wb(cyc + 4);
        next_cycle();
        force u_dut.stall_cycles = 32'hFFFF_FFFE;
        #1;
        release u_dut.stall_cycles;
        apply(mk(1, 1, 15, 1, 14, -1, -1, 0));
        for (int k = 1; k <= 3; k++) begin
            mid();
            check("sat_stall", 32'(issue_stall), 32'h1);
            check("sat_count", stall_cycles, (k == 1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
            next_cycle();
        end
        mid();
        check("sat_fire", 32'(issue_fire), 32'h1);
        check("sat_hold", stall_cycles, 32'hFFFF_FFFF);
        expect_wb(cyc + 1);
        next_cycle();
        apply(idle);
        repeat (3) next_cycle();
        mid();
        check("wb_queue_empty", 32'(wb_q.size()), 32'h0);
        check("final_any_busy", 32'(any_busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
